// File: rtl/store_align_unit.sv
// Store-side byte-lane aligner and data-bus request sequencer for the memory stage.
// Optional build macro STORE_BUF_EN turns the request registers into a one-entry store buffer.
module store_align_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [63:0] st_addr,
    input  logic [1:0]  st_msize,
    input  logic [63:0] st_data,
    output logic        st_ready,
    output logic        store_misalign,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    output logic [63:0] dreq_data,
    output logic [7:0]  dreq_strobe,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    output logic        busy
);

    localparam logic [1:0] MSIZE1 = 2'd0;
    localparam logic [1:0] MSIZE2 = 2'd1;
    localparam logic [1:0] MSIZE4 = 2'd2;
    localparam logic [1:0] MSIZE8 = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    function automatic logic f_is_aligned(input logic [2:0] off, input logic [1:0] sz);
        logic ok;
        case (sz)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (off[0] == 1'b0);
            MSIZE4:  ok = (off[1:0] == 2'b00);
            default: ok = (off == 3'b000);
        endcase
        return ok;
    endfunction

    function automatic logic [7:0] f_strobe(input logic [2:0] off, input logic [1:0] sz);
        logic [7:0] base;
        case (sz)
            MSIZE1:  base = 8'h01;
            MSIZE2:  base = 8'h03;
            MSIZE4:  base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    // Bytes above the access size are cleared so unused lanes read as zero.
    function automatic logic [63:0] f_lane_data(input logic [63:0] data, input logic [2:0] off,
                                                input logic [1:0] sz);
        logic [63:0] masked;
        case (sz)
            MSIZE1:  masked = {56'd0, data[7:0]};
            MSIZE2:  masked = {48'd0, data[15:0]};
            MSIZE4:  masked = {32'd0, data[31:0]};
            default: masked = data;
        endcase
        return masked << {off, 3'b000};
    endfunction

    logic [1:0]  r_state;
    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_data;
    logic [7:0]  r_strobe;

    logic        w_idle;
    logic        w_aligned;
    logic        w_accept;
    logic        w_done;
    logic [63:0] w_lane_data;
    logic [7:0]  w_strobe;

    assign w_idle      = (r_state == S_IDLE);
    assign w_aligned   = f_is_aligned(st_addr[2:0], st_msize);
    assign w_accept    = w_idle && st_valid && w_aligned;
    assign w_done      = ((r_state == S_ADDR) && dresp_addr_ok && dresp_data_ok) ||
                         ((r_state == S_DATA) && dresp_data_ok);
    assign w_lane_data = f_lane_data(st_data, st_addr[2:0], st_msize);
    assign w_strobe    = f_strobe(st_addr[2:0], st_msize);

`ifdef STORE_BUF_EN
    // Buffered: the store retires at acceptance; anything arriving while busy waits for IDLE.
    assign store_misalign = !reset && st_valid && !w_aligned && w_idle;
    assign st_ready       = !reset && st_valid && w_idle;
`else
    assign store_misalign = !reset && st_valid && !w_aligned;
    assign st_ready       = !reset && (w_done || store_misalign);
`endif

    assign dreq_valid  = (r_state == S_ADDR);
    assign busy        = !w_idle;
    assign dreq_addr   = r_addr;
    assign dreq_size   = r_size;
    assign dreq_data   = r_data;
    assign dreq_strobe = r_strobe;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= 64'd0;
            r_size   <= 2'd0;
            r_data   <= 64'd0;
            r_strobe <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state  <= S_ADDR;
                        r_addr   <= {st_addr[63:3], 3'b000};
                        r_size   <= st_msize;
                        r_data   <= w_lane_data;
                        r_strobe <= w_strobe;
                    end
                end
                // A data_ok without addr_ok in this state is ignored.
                S_ADDR: begin
                    if (dresp_addr_ok) begin
                        r_state <= dresp_data_ok ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (dresp_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
